// File: rtl/anubis_pkg.sv
// rtl/anubis_pkg.sv - shared types, constants and GF(2^8) helper for the Anubis theta layer
package anubis_pkg;

  localparam logic [7:0] GF_POLY_LOW = 8'h1d;
  localparam int         WORDS       = 4;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_LOW : 8'h00);
  endfunction

endpackage

// File: rtl/anubis_theta_col.sv
// rtl/anubis_theta_col.sv - combinational 32-bit column mixer (Anubis H matrix)
module anubis_theta_col
  import anubis_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b  [4];
  logic [7:0] m2 [4];
  logic [7:0] m4 [4];
  logic [7:0] m6 [4];

  // Per-byte multiples 2, 4 and 6, then the fixed H-matrix row combinations; b[0] is the MSB byte
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]  = col_in[31-8*i -: 8];
      m2[i] = gf_xtime(b[i]);
      m4[i] = gf_xtime(m2[i]);
      m6[i] = m4[i] ^ m2[i];
    end
    col_out[31:24] = b[0]  ^ m2[1] ^ m4[2] ^ m6[3];
    col_out[23:16] = m2[0] ^ b[1]  ^ m6[2] ^ m4[3];
    col_out[15:8]  = m4[0] ^ m6[1] ^ b[2]  ^ m2[3];
    col_out[7:0]   = m6[0] ^ m4[1] ^ m2[2] ^ b[3];
  end

endmodule

// File: rtl/anubis_theta_seq.sv
// rtl/anubis_theta_seq.sv - theta diffusion sequencer, LANES column mixers per cycle
module anubis_theta_seq
  import anubis_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int STEPS = (LANES > 0) ? (WORDS / LANES) : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
    $fatal(1, "anubis_theta_seq: LANES must be 1, 2 or 4");
  end

  fsm_t          fsm_q;
  fsm_t          fsm_d;
  logic [CW-1:0] cnt_q;
  state_t        data_q;
  state_t        mixed;
  logic          accept;
  logic          last_step;

  logic [31:0] words       [WORDS];
  logic [31:0] words_mixed [WORDS];
  logic [1:0]  wsel        [LANES];
  logic [31:0] col_in      [LANES];
  logic [31:0] col_out     [LANES];

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CW'(STEPS - 1));

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
  assign out_data  = data_q;

  // Lane k handles word cnt*LANES+k of the current group
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign wsel[k]   = 2'(int'(cnt_q) * LANES + k);
    assign col_in[k] = words[wsel[k]];
    anubis_theta_col u_col (
      .col_in  (col_in[k]),
      .col_out (col_out[k])
    );
  end

  // Unpack the state, splice the mixed group back in, repack
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      words[i] = data_q[127-32*i -: 32];
    end
    for (int i = 0; i < WORDS; i++) begin
      words_mixed[i] = words[i];
    end
    for (int k = 0; k < LANES; k++) begin
      words_mixed[wsel[k]] = col_out[k];
    end
    mixed = {words_mixed[0], words_mixed[1], words_mixed[2], words_mixed[3]};
  end

  // Next-state logic: bypass goes straight to DONE, RUN leaves after the last group
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = in_bypass ? DONE : RUN;
      RUN:     if (last_step) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // State register and group counter; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) data_q <= in_data;
          cnt_q <= '0;
        end
        RUN: begin
          data_q <= mixed;
          cnt_q  <= last_step ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_theta_seq.sv
// tb/tb_anubis_theta_seq.sv - self-checking bench for anubis_theta_seq at LANES 1, 2, 4
module tb_anubis_theta_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         in_bypass [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    anubis_theta_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_bypass (in_bypass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  // Reference model: generic GF(2^8) multiply and H as a plain coefficient table
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011d << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] h [16] = '{8'd1, 8'd2, 8'd4, 8'd6,
                           8'd2, 8'd1, 8'd6, 8'd4,
                           8'd4, 8'd6, 8'd1, 8'd2,
                           8'd6, 8'd4, 8'd2, 8'd1};
    logic [7:0]  y;
    logic [31:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      y = '0;
      for (int c = 0; c < 4; c++) y = y ^ gmul(h[row*4+c], w[31-8*c -: 8]);
      r[31-8*row -: 8] = y;
    end
    return r;
  endfunction

  function automatic logic [127:0] theta_model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[127-32*i -: 32] = mix_word(s[127-32*i -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one state through instance idx with out_ready=1; lat counts edges after the accept edge
  task automatic run_one(input int idx, input logic [127:0] d, input logic byp,
                         output logic [127:0] res, output int lat, output bit ok);
    int wd;
    ok = 1'b1;
    @(negedge clk);
    in_valid[idx]  = 1'b1;
    in_data[idx]   = d;
    in_bypass[idx] = byp;
    out_ready[idx] = 1'b1;
    wd = 0;
    while (!in_ready[idx] && wd < 50) begin
      @(negedge clk);
      wd++;
    end
    if (!in_ready[idx]) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    lat = 0;
    while (!out_valid[idx] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[idx]) ok = 1'b0;
    res = out_data[idx];
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; in_bypass[i] = 1'b0; out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || out_data[i] !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
                 i, in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_vector();
    logic [127:0] res;
    logic [127:0] exp;
    int lat;
    bit ok;
    exp = {32'h01020406, 32'h06040201, 32'h801d3a27, 32'h0};
    run_one(0, {32'h01000000, 32'h00000001, 32'h80000000, 32'h0}, 1'b0, res, lat, ok);
    n_cmp++;
    if (!ok || res !== exp) begin
      n_fail++;
      $display("FAIL vector: out_data=%h ok=%0d, required %h", res, ok, exp);
    end
    n_cmp++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL vector_latency: %0d, required 4", lat);
    end
  endtask

  task automatic test_involution();
    logic [127:0] x, r1, r2;
    int lat1, lat2;
    bit ok1, ok2;
    for (int idx = 0; idx < 3; idx++) begin
      for (int t = 0; t < 2; t++) begin
        x = rand128();
        run_one(idx, x, 1'b0, r1, lat1, ok1);
        run_one(idx, r1, 1'b0, r2, lat2, ok2);
        n_cmp++;
        if (!ok1 || r1 !== theta_model(x)) begin
          n_fail++;
          $display("FAIL involution_first[L%0d]: %h, required %h", 1 << idx, r1, theta_model(x));
        end
        n_cmp++;
        if (!ok2 || r2 !== x) begin
          n_fail++;
          $display("FAIL involution_back[L%0d]: %h, required %h", 1 << idx, r2, x);
        end
        n_cmp++;
        if (lat1 != (4 >> idx) || lat2 != (4 >> idx)) begin
          n_fail++;
          $display("FAIL involution_latency[L%0d]: %0d/%0d, required %0d", 1 << idx, lat1, lat2, 4 >> idx);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [127:0] d, res;
    int lat;
    bit ok;
    d = 128'h0123456789abcdef0123456789abcdef;
    for (int idx = 0; idx < 3; idx++) begin
      run_one(idx, d, 1'b1, res, lat, ok);
      n_cmp++;
      if (!ok || res !== d) begin
        n_fail++;
        $display("FAIL bypass_data[L%0d]: %h, required %h", 1 << idx, res, d);
      end
      n_cmp++;
      if (lat != 0) begin
        n_fail++;
        $display("FAIL bypass_latency[L%0d]: valid %0d edges late, required in the cycle after accept", 1 << idx, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b2, ea, eb;
    int wd;
    a  = rand128();
    b2 = rand128();
    ea = theta_model(a);
    eb = theta_model(b2);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = a; in_bypass[0] = 1'b0; out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = b2;
    wd = 0;
    while (!out_valid[0] && wd < 50) begin
      @(negedge clk);
      wd++;
    end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== ea || in_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%h in_ready=%b, required 1 %h 0",
                 c, out_valid[0], out_data[0], in_ready[0], ea);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready[0], out_valid[0]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_second_accept: busy=%b, required 1", busy[0]);
    end
    wd = 0;
    while (!out_valid[0] && wd < 50) begin
      @(negedge clk);
      wd++;
    end
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== eb) begin
      n_fail++;
      $display("FAIL backpressure_second_data: %h valid=%b, required %h", out_data[0], out_valid[0], eb);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] a, c, res;
    int lat;
    bit ok;
    a = rand128();
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = a; in_bypass[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_data[0] !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: valid=%b in_ready=%b busy=%b data=%h, required 0 1 0 0",
               out_valid[0], in_ready[0], busy[0], out_data[0]);
    end
    rst = 1'b0;
    c = rand128();
    run_one(0, c, 1'b0, res, lat, ok);
    n_cmp++;
    if (!ok || res !== theta_model(c) || lat != 4) begin
      n_fail++;
      $display("FAIL reset_recover: %h lat=%0d, required %h lat=4", res, lat, theta_model(c));
    end
  endtask

  task automatic test_random_stream(input int idx, input int cnt);
    logic [127:0] q [$];
    logic [127:0] d, e;
    logic b;
    int got, wdp, wdc;
    bit tmo;
    got = 0;
    tmo = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int n = 0; n < cnt; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d = rand128();
          b = ($urandom_range(0, 4) == 0);
          in_valid[idx] = 1'b1; in_data[idx] = d; in_bypass[idx] = b;
          wdp = 0;
          while (!in_ready[idx] && wdp < 200) begin
            @(negedge clk);
            wdp++;
          end
          if (!in_ready[idx]) begin
            tmo = 1'b1;
            in_valid[idx] = 1'b0;
            break;
          end
          q.push_back(b ? d : theta_model(d));
          @(negedge clk);
          in_valid[idx] = 1'b0;
        end
      end
      begin
        wdc = 0;
        while (got < cnt && wdc < cnt * 40) begin
          out_ready[idx] = ($urandom_range(0, 9) < 7);
          if (out_valid[idx] && out_ready[idx]) begin
            n_cmp++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL stream[L%0d] #%0d: unexpected output %h, required none", 1 << idx, got, out_data[idx]);
            end else begin
              e = q.pop_front();
              if (out_data[idx] !== e) begin
                n_fail++;
                $display("FAIL stream[L%0d] #%0d: %h, required %h", 1 << idx, got, out_data[idx], e);
              end
            end
            got++;
          end
          @(negedge clk);
          wdc++;
        end
        out_ready[idx] = 1'b0;
      end
    join
    n_cmp++;
    if (tmo || got != cnt || q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count[L%0d]: got=%0d pending=%0d timeout=%0d, required %0d 0 0",
               1 << idx, got, q.size(), tmo, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_involution();
    test_bypass();
    test_backpressure();
    test_reset_mid_run();
    test_random_stream(0, 1000);
    test_random_stream(1, 300);
    test_random_stream(2, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
